// File: rtl/multi_ratio_clock_divider.sv
// multi_ratio_clock_divider
// Runtime-selectable clock divider: one registered divided output whose ratio
// comes from div_a or div_b depending on switch. A new ratio or selection is
// only adopted at a period wrap, so the output never gets a truncated or
// stretched period.
// Optional build macro: SWITCH_SYNC_EN. When defined, switch passes through a
// SYNC_STAGES-deep synchroniser before it is used. When undefined, switch is
// sampled directly and must already be synchronous to clock.
module multi_ratio_clock_divider #(
  parameter int CNT_W       = 16,
  parameter int DIV_RESET   = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             switch,
  input  logic [CNT_W-1:0] div_a,
  input  logic [CNT_W-1:0] div_b,
  output logic             choosen_clock,
  output logic [CNT_W-1:0] phase,
  output logic             tick,
  output logic             sel_active,
  output logic [CNT_W-1:0] div_active
);

  // A ratio below 2 cannot produce a low and a high half, so it is raised to 2.
  localparam logic [CNT_W-1:0] MIN_DIV           = CNT_W'(2);
  localparam logic [CNT_W-1:0] DIV_RESET_CLAMPED = (DIV_RESET < 2) ? MIN_DIV : CNT_W'(DIV_RESET);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("multi_ratio_clock_divider: SYNC_STAGES must be in 2..4");
  end

  logic             switch_sampled;
  logic             wrap;
  logic [CNT_W-1:0] div_selected;
  logic [CNT_W-1:0] div_clamped;
  logic [CNT_W-1:0] phase_next;
  logic             clock_next;

`ifdef SWITCH_SYNC_EN
  logic [SYNC_STAGES-1:0] switch_sync;

  // Shift switch through the synchroniser chain; the last stage feeds the wrap latch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      switch_sync <= '0;
    end else begin
      switch_sync <= {switch_sync[SYNC_STAGES-2:0], switch};
    end
  end

  assign switch_sampled = switch_sync[SYNC_STAGES-1];
`else
  assign switch_sampled = switch;
`endif

  // Work out the wrap condition, the ratio to adopt at wrap, and the next phase and output level.
  always_comb begin
    wrap         = enable && (phase == (div_active - CNT_W'(1)));
    div_selected = switch_sampled ? div_b : div_a;
    div_clamped  = (div_selected < MIN_DIV) ? MIN_DIV : div_selected;
    phase_next   = wrap ? '0 : (phase + CNT_W'(1));
    // High for the last floor(N/2) phases; phase 0 after a wrap is always low.
    clock_next   = (phase_next >= (div_active - (div_active >> 1)));
  end

  // Advance the phase counter on enabled cycles and latch the new ratio only at wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase         <= '0;
      choosen_clock <= 1'b0;
      tick          <= 1'b0;
      sel_active    <= 1'b0;
      div_active    <= DIV_RESET_CLAMPED;
    end else if (enable) begin
      phase         <= phase_next;
      choosen_clock <= clock_next;
      tick          <= wrap;
      if (wrap) begin
        sel_active <= switch_sampled;
        div_active <= div_clamped;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_ratio_clock_divider.sv
// tb_multi_ratio_clock_divider
// Self-checking bench for multi_ratio_clock_divider. A period-level reference
// model (position within the current period, period length, selection) is
// advanced on every rising edge and compared against all outputs.
// Honours SWITCH_SYNC_EN the same way the design does.
module tb_multi_ratio_clock_divider;

  localparam int CNT_W       = 16;
  localparam int DIV_RESET   = 6;
  localparam int SYNC_STAGES = 2;
  localparam int OBS_W       = 2 * CNT_W + 3;

  logic             clock;
  logic             reset;
  logic             enable;
  logic             switch;
  logic [CNT_W-1:0] div_a;
  logic [CNT_W-1:0] div_b;
  logic             choosen_clock;
  logic [CNT_W-1:0] phase;
  logic             tick;
  logic             sel_active;
  logic [CNT_W-1:0] div_active;

  int checks;
  int errors;

  // Reference model state
  int m_pos;
  int m_len;
  int m_sel;
  int m_tick;
  int m_sw_hist[SYNC_STAGES];

  multi_ratio_clock_divider #(
    .CNT_W      (CNT_W),
    .DIV_RESET  (DIV_RESET),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .switch       (switch),
    .div_a        (div_a),
    .div_b        (div_b),
    .choosen_clock(choosen_clock),
    .phase        (phase),
    .tick         (tick),
    .sel_active   (sel_active),
    .div_active   (div_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int clamp_ratio(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  // Expected output: low for the first ceil(N/2) positions of a period, high afterwards.
  function automatic logic [OBS_W-1:0] expected_vec();
    logic high;
    high = (m_pos >= (m_len + 1) / 2);
    return {CNT_W'(m_pos), high, (m_tick != 0), (m_sel != 0), CNT_W'(m_len)};
  endfunction

  function automatic logic [OBS_W-1:0] observed_vec();
    return {phase, choosen_clock, tick, sel_active, div_active};
  endfunction

  task automatic model_reset();
    m_pos  = 0;
    m_len  = clamp_ratio(DIV_RESET);
    m_sel  = 0;
    m_tick = 0;
    for (int i = 0; i < SYNC_STAGES; i++) m_sw_hist[i] = 0;
  endtask

  // Advance DUT and model by one rising edge; outputs settle 1 time unit later.
  task automatic run_cycle();
    int sw_seen;
    @(posedge clock);
`ifdef SWITCH_SYNC_EN
    sw_seen = m_sw_hist[SYNC_STAGES-1];
    for (int i = SYNC_STAGES - 1; i > 0; i--) m_sw_hist[i] = m_sw_hist[i-1];
    m_sw_hist[0] = int'(switch);
`else
    sw_seen = int'(switch);
`endif
    if (enable) begin
      if (m_pos + 1 == m_len) begin
        m_pos  = 0;
        m_tick = 1;
        m_sel  = sw_seen;
        m_len  = clamp_ratio(sw_seen != 0 ? int'(div_b) : int'(div_a));
      end else begin
        m_pos  = m_pos + 1;
        m_tick = 0;
      end
    end else begin
      m_tick = 0;
    end
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic sw, input int a, input int b);
    enable = en;
    switch = sw;
    div_a  = CNT_W'(a);
    div_b  = CNT_W'(b);
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 1'b0, 6, 6);
    reset = 1'b0;
    model_reset();
    #1;
    if (observed_vec() !== expected_vec()) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h expected %h", observed_vec(), expected_vec());
    end
    checks++;
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_basic_div6();
    applyStimulus(1'b1, 1'b0, 6, 6);
    for (int c = 1; c <= 18; c++) begin
      run_cycle();
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL basic_div6 cycle %0d: got %h expected %h", c, observed_vec(), expected_vec());
      end
      checks++;
      if (c == 6 && tick !== 1'b1) begin
        errors++;
        $display("[TB] FAIL first_tick_cycle6: tick=%b expected 1", tick);
      end
      if (c == 6) checks++;
    end
  endtask

  task automatic test_switch_midperiod();
    int guard;
    guard = 0;
    while (m_pos != 2 && guard < 40) begin
      run_cycle();
      guard++;
    end
    if (m_pos != 2) begin
      errors++;
      $display("[TB] FAIL switch_setup: model phase %0d expected 2", m_pos);
    end
    checks++;
    applyStimulus(1'b1, 1'b1, 6, 4);
    for (int c = 1; c <= 16; c++) begin
      run_cycle();
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL switch_midperiod cycle %0d: got %h expected %h", c, observed_vec(), expected_vec());
      end
      checks++;
    end
  endtask

  task automatic test_odd_and_clamp();
    int ratios[3] = '{5, 0, 1};
    foreach (ratios[r]) begin
      applyStimulus(1'b1, 1'b0, ratios[r], 4);
      for (int c = 1; c <= 14; c++) begin
        run_cycle();
        if (observed_vec() !== expected_vec()) begin
          errors++;
          $display("[TB] FAIL ratio_%0d cycle %0d: got %h expected %h", ratios[r], c, observed_vec(), expected_vec());
        end
        checks++;
      end
    end
  endtask

  task automatic test_enable_hold();
    int guard;
    applyStimulus(1'b1, 1'b0, 6, 4);
    guard = 0;
    while (!(m_len == 6 && m_pos == 3) && guard < 60) begin
      run_cycle();
      guard++;
    end
    if (!(m_len == 6 && m_pos == 3)) begin
      errors++;
      $display("[TB] FAIL enable_setup: model N=%0d phase=%0d expected N=6 phase=3", m_len, m_pos);
    end
    checks++;
    enable = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      run_cycle();
      if (observed_vec() !== expected_vec() || phase !== 16'd3 || choosen_clock !== 1'b1) begin
        errors++;
        $display("[TB] FAIL enable_hold cycle %0d: got %h expected %h", c, observed_vec(), expected_vec());
      end
      checks++;
    end
    enable = 1'b1;
    run_cycle();
    if (observed_vec() !== expected_vec() || phase !== 16'd4) begin
      errors++;
      $display("[TB] FAIL enable_resume: got %h expected %h", observed_vec(), expected_vec());
    end
    checks++;
  endtask

  task automatic test_reset_midperiod();
    int guard;
    int first_tick;
    applyStimulus(1'b1, 1'b1, 6, 4);
    guard = 0;
    while (!(m_len == 4 && m_pos == 3) && guard < 60) begin
      run_cycle();
      guard++;
    end
    if (!(m_len == 4 && m_pos == 3)) begin
      errors++;
      $display("[TB] FAIL reset_mid_setup: model N=%0d phase=%0d expected N=4 phase=3", m_len, m_pos);
    end
    checks++;
    reset = 1'b0;
    model_reset();
    #1;
    if (observed_vec() !== expected_vec()) begin
      errors++;
      $display("[TB] FAIL reset_mid_async: got %h expected %h", observed_vec(), expected_vec());
    end
    checks++;
    #1;
    reset = 1'b1;
    first_tick = 0;
    for (int c = 1; c <= 8; c++) begin
      run_cycle();
      if (tick === 1'b1 && first_tick == 0) first_tick = c;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL reset_mid_resume cycle %0d: got %h expected %h", c, observed_vec(), expected_vec());
      end
      checks++;
    end
    if (first_tick != 6) begin
      errors++;
      $display("[TB] FAIL reset_mid_first_tick: got cycle %0d expected 6", first_tick);
    end
    checks++;
  endtask

`ifdef SWITCH_SYNC_EN
  task automatic test_switch_sync();
    int guard;
    applyStimulus(1'b1, 1'b0, 6, 3);
    guard = 0;
    while (!(m_len == 6 && m_sel == 0 && m_pos == 4) && guard < 60) begin
      run_cycle();
      guard++;
    end
    switch = 1'b1;
    run_cycle();
    run_cycle();
    if (sel_active !== 1'b0 || div_active !== 16'd6 || tick !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sync_old_ratio_kept: sel=%b div=%0d tick=%b expected sel=0 div=6 tick=1", sel_active, div_active, tick);
    end
    checks++;
    for (int c = 1; c <= 12; c++) begin
      run_cycle();
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL switch_sync cycle %0d: got %h expected %h", c, observed_vec(), expected_vec());
      end
      checks++;
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 1; c <= 400; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 5) == 0) switch = ~switch;
      if ($urandom_range(0, 3) == 0) div_a = CNT_W'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) div_b = CNT_W'($urandom_range(0, 9));
      run_cycle();
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got %h expected %h", c, observed_vec(), expected_vec());
      end
      checks++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    applyStimulus(1'b0, 1'b0, 6, 6);
    model_reset();
    #2;
    test_reset();
    test_basic_div6();
    test_switch_midperiod();
    test_odd_and_clamp();
    test_enable_hold();
    test_reset_midperiod();
`ifdef SWITCH_SYNC_EN
    test_switch_sync();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
